parking_gate_ctrl: RTL
======================

Name: parking_gate_ctrl

Overview:
- Event initiator for the parking occupancy counter. Drives its car_entered / is_uni_car_entered / car_exited / is_uni_car_exited inputs.
- Converts raw gate sensors (arrival loop, badge reader, pass-through beam) into barrier control and one-cycle pass events.
- The entry barrier is gated by the counter's vacancy flags (uni_is_vacated_space, is_vacated_space).
- Two independent gate FSMs (entry, exit) share one clock.

Parameters:
OPEN_TIMEOUT, 32, max cycles barrier stays open waiting for the pass beam before auto-close (no event)
CLOSE_CYCLES, 4, cycles barrier spends in CLOSING before the gate re-arms
DENY_CYCLES, 8, cycles the deny lamp stays lit after a refused entry

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_arrive  in  1  entry loop sensor, level; car waiting at entry
in_badge_uni  in  1  entry badge = university car; sampled with arrival
in_pass  in  1  entry beam; high while a car passes under barrier
out_arrive  in  1  exit loop sensor, level
out_badge_uni  in  1  exit badge = university car
out_pass  in  1  exit beam
uni_is_vacated_space  in  1  counter flag: uni slot free
is_vacated_space  in  1  counter flag: public slot free
car_entered  out  1  one-cycle pulse, car passed entry
is_uni_car_entered  out  1  class of entering car, valid with car_entered
car_exited  out  1  one-cycle pulse, car passed exit
is_uni_car_exited  out  1  class of exiting car, valid with car_exited
in_barrier_open  out  1  entry barrier raise command
out_barrier_open  out  1  exit barrier raise command
in_deny  out  1  entry deny lamp

Behaviour:
- Reset (synchronous, active-high): all outputs 0, both FSMs IDLE, timers 0, edge registers 0. Reset mid-operation aborts at the next clk edge with no pulse emitted.
- Arrival is rising-edge detected (registered previous value). A car held on the loop triggers once only.
- Entry FSM states: IDLE, OPEN, CLOSING, DENY.
  - IDLE: on in_arrive rise, latch class = in_badge_uni.
  - Free flag is uni_is_vacated_space for a uni car, is_vacated_space otherwise, sampled the same cycle.
  - Free -> OPEN; not free -> DENY.
  - OPEN: in_barrier_open=1; timer counts up.
  - OPEN, in_pass falling edge (car fully through) -> car_entered=1 and is_uni_car_entered=latched class for exactly that cycle -> CLOSING.
  - OPEN, timer reaches OPEN_TIMEOUT-1 without pass -> CLOSING, no pulse.
  - CLOSING: barrier 0 for CLOSE_CYCLES, then IDLE. Arrival rises during CLOSING are ignored; the car must re-trigger.
  - DENY: in_deny=1 for DENY_CYCLES, then IDLE.
- Exit FSM states: IDLE, OPEN, CLOSING. Same as entry, but no vacancy check and no deny; it always opens on out_arrive rise.
- is_uni_car_* is 0 whenever the matching pulse is 0.
- Vacancy is sampled only at arrival. A flag change while OPEN does not close the barrier.
- Entry and exit pulses in the same cycle are allowed; the counter handles the simultaneous case.
- Pass beam high on arrival edge: ignored; only a falling edge inside OPEN counts.
- Timers are $clog2(max param)+1 bits, saturate-free, cleared on every state entry.

Optional Feature:
PARKING_GATE_ANTIPASSBACK_EN
- Defined: a 10-bit register uni_inside is added.
  - Incremented on a uni car_entered; decremented on a uni car_exited, saturating at 0.
  - A uni exit request with uni_inside==0 is treated as public (is_uni_car_exited=0).
  - Blocks badge reuse to drain the uni count.
- Undefined: register absent; exit class = out_badge_uni as latched.

Decomposition:
- Package parking_gate_pkg:
  - gate_state_e enum (IDLE, OPEN, CLOSING, DENY)
  - default timing constants
  - TIMER_W localparam function
- Natural sub-module parking_gate_fsm, instantiated twice. Parameter HAS_DENY (1 entry, 0 exit). Inputs arrive, badge, pass, allow. Exit ties allow=1.
- Top holds vacancy selection and the optional anti-passback register.

Test Plan:
- Reset 1 for 2 cycles, mid-OPEN: all outputs 0 next edge; no car_entered afterwards despite in_pass falling.
- Uni arrive, uni_is_vacated_space=1, in_pass high 3 cycles then low: in_barrier_open next cycle; car_entered=1, is_uni_car_entered=1 for exactly 1 cycle after pass fall; barrier low; IDLE after 4 cycles.
- Public arrive with is_vacated_space=0: in_deny=1 for 8 cycles, no barrier, no pulse. Loop held high afterwards: no retrigger.
- Entry open, no pass for 32 cycles: auto-close, car_entered never asserted.
- Entry and exit passes falling the same cycle: car_entered and car_exited both 1 that cycle with correct classes.
- With PARKING_GATE_ANTIPASSBACK_EN: uni exit with no prior uni entry gives car_exited=1, is_uni_car_exited=0. After one uni entry, uni exit gives is_uni_car_exited=1.

Source files
------------

// File: rtl/parking_gate_pkg.sv
// Shared types and timing defaults for the parking gate controller.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package parking_gate_pkg;

    // Gate FSM states. The exit gate never enters DENY.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2,
        DENY    = 2'd3
    } gate_state_e;

    // Default timing, in core clock cycles.
    localparam int DEF_OPEN_TIMEOUT = 32;
    localparam int DEF_CLOSE_CYCLES = 4;
    localparam int DEF_DENY_CYCLES  = 8;

    // The timer must hold the largest terminal count; one extra bit keeps
    // power-of-two maxima representable without wrap.
    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One gate: arrival edge detect, barrier/deny sequencing, one-cycle pass event.
// Latency: barrier rises 1 cycle after the arrival edge; pass pulse 1 cycle after the beam falls.
// Backpressure: none; sensor levels are sampled every cycle and events are never held off.
import parking_gate_pkg::*;

module parking_gate_fsm #(
    parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int DENY_CYCLES  = DEF_DENY_CYCLES,
    parameter bit HAS_DENY     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic arrive_i,
    input  logic badge_i,
    input  logic pass_i,
    input  logic allow_i,
    output logic pulse_o,
    output logic pulse_uni_o,
    output logic barrier_o,
    output logic deny_o
);

    localparam int TW = timer_w(OPEN_TIMEOUT, CLOSE_CYCLES, DENY_CYCLES);
    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
    localparam logic [TW-1:0] DENY_LAST  = TW'(DENY_CYCLES - 1);

    gate_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          arrive_prev_q;
    logic          pass_prev_q;
    logic          class_q, class_d;
    logic          pulse_q, pulse_d;
    logic          pulse_uni_q, pulse_uni_d;

    logic arrive_rise;
    logic pass_fall;

    // A car parked on the loop gives a single rise; only the beam's trailing
    // edge means the car has fully cleared the barrier.
    assign arrive_rise = arrive_i & ~arrive_prev_q;
    assign pass_fall   = pass_prev_q & ~pass_i;

    // Next state, timer, class latch and pass pulse; the timer restarts on every state change.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        class_d     = class_q;
        pulse_d     = 1'b0;
        pulse_uni_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (arrive_rise) begin
                    class_d = badge_i;
                    if (allow_i || !HAS_DENY) begin
                        state_d = OPEN;
                    end else begin
                        state_d = DENY;
                    end
                end
            end
            OPEN: begin
                if (pass_fall) begin
                    pulse_d     = 1'b1;
                    pulse_uni_d = class_q;
                    state_d     = CLOSING;
                    timer_d     = '0;
                end else if (timer_q == OPEN_LAST) begin
                    state_d = CLOSING;
                    timer_d = '0;
                end
            end
            CLOSING: begin
                // Arrival edges are deliberately not looked at here.
                if (timer_q == CLOSE_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            DENY: begin
                if (timer_q == DENY_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State, timer, edge history and registered event outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            arrive_prev_q <= 1'b0;
            pass_prev_q   <= 1'b0;
            class_q       <= 1'b0;
            pulse_q       <= 1'b0;
            pulse_uni_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            arrive_prev_q <= arrive_i;
            pass_prev_q   <= pass_i;
            class_q       <= class_d;
            pulse_q       <= pulse_d;
            pulse_uni_q   <= pulse_uni_d;
        end
    end

    assign pulse_o     = pulse_q;
    assign pulse_uni_o = pulse_uni_q;
    assign barrier_o   = (state_q == OPEN);
    assign deny_o      = HAS_DENY && (state_q == DENY);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate controller feeding the occupancy counter; optional PARKING_GATE_ANTIPASSBACK_EN.
// Latency: barrier 1 cycle after arrival edge; car_entered/car_exited 1 cycle after beam fall.
// Backpressure: none; vacancy flags gate entry only at the arrival edge.
import parking_gate_pkg::*;

module parking_gate_ctrl #(
    parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int DENY_CYCLES  = DEF_DENY_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in_arrive,
    input  logic in_badge_uni,
    input  logic in_pass,
    input  logic out_arrive,
    input  logic out_badge_uni,
    input  logic out_pass,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic in_barrier_open,
    output logic out_barrier_open,
    output logic in_deny
);

    logic entry_allow;
    logic exit_badge;
    logic entry_deny;
    logic exit_deny;

    // Each car class checks its own pool of free slots.
    assign entry_allow = in_badge_uni ? uni_is_vacated_space : is_vacated_space;

`ifdef PARKING_GATE_ANTIPASSBACK_EN
    logic [9:0] uni_inside_q, uni_inside_d;
    logic       uni_in_evt;
    logic       uni_out_evt;

    // A uni badge can only claim uni status at exit while uni cars are inside,
    // so reusing one badge cannot drain the uni count below reality.
    assign exit_badge  = out_badge_uni && (uni_inside_q != 10'd0);
    assign uni_in_evt  = car_entered && is_uni_car_entered;
    assign uni_out_evt = car_exited && is_uni_car_exited;

    // Uni-inside count: up on uni entry, down on uni exit, clamped at both ends.
    always_comb begin
        uni_inside_d = uni_inside_q;
        if (uni_in_evt && !uni_out_evt) begin
            if (uni_inside_q != 10'h3FF) begin
                uni_inside_d = uni_inside_q + 10'd1;
            end
        end else if (uni_out_evt && !uni_in_evt) begin
            if (uni_inside_q != 10'd0) begin
                uni_inside_d = uni_inside_q - 10'd1;
            end
        end
    end

    // Uni-inside register.
    always_ff @(posedge clk) begin
        if (reset) begin
            uni_inside_q <= 10'd0;
        end else begin
            uni_inside_q <= uni_inside_d;
        end
    end
`else
    assign exit_badge = out_badge_uni;
`endif

    parking_gate_fsm #(
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES),
        .DENY_CYCLES  (DENY_CYCLES),
        .HAS_DENY     (1'b1)
    ) u_entry (
        .clk         (clk),
        .reset       (reset),
        .arrive_i    (in_arrive),
        .badge_i     (in_badge_uni),
        .pass_i      (in_pass),
        .allow_i     (entry_allow),
        .pulse_o     (car_entered),
        .pulse_uni_o (is_uni_car_entered),
        .barrier_o   (in_barrier_open),
        .deny_o      (entry_deny)
    );

    parking_gate_fsm #(
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES),
        .DENY_CYCLES  (DENY_CYCLES),
        .HAS_DENY     (1'b0)
    ) u_exit (
        .clk         (clk),
        .reset       (reset),
        .arrive_i    (out_arrive),
        .badge_i     (exit_badge),
        .pass_i      (out_pass),
        .allow_i     (1'b1),
        .pulse_o     (car_exited),
        .pulse_uni_o (is_uni_car_exited),
        .barrier_o   (out_barrier_open),
        .deny_o      (exit_deny)
    );

    // The exit instance has no deny path, so this is the entry lamp alone.
    assign in_deny = entry_deny | exit_deny;

endmodule
